// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, machine word and the poison value
// returned on failed memory accesses.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    localparam word_t BadWord = 32'hBAD1BAD1;

endpackage

// File: rtl/svc_timer.sv
// Service-cycle counter for mem_responder; expired flags the TIMEOUT-th cycle of a service.
module svc_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed service cycles, so this fires in service cycle TIMEOUT
    assign expired = en && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_responder.sv
// Arbitrates instruction and data requests onto a single RAM port, with timeout and
// sticky error reporting; completions are signalled by a one-cycle registered wait-low.
module mem_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    typedef enum logic [1:0] {
        StIdle,
        StDServ,
        StIServ
    } state_e;

    state_e state_q, state_d;
    word_t  addr_q, addr_d;
    word_t  store_q, store_d;
    logic   wen_q, wen_d;
    logic   last_data_q, last_data_d;
    logic   iwait_q, iwait_d;
    logic   dwait_q, dwait_d;
    word_t  iload_q, iload_d;
    word_t  dload_q, dload_d;
    logic   err_q, err_d;

    logic   expired;
    logic   timer_clr;
    logic   timer_en;
    logic   dreq;
    logic   req_held;
    logic   done;
    word_t  done_val;

    svc_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_svc_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        store_d     = store_q;
        wen_d       = wen_q;
        last_data_d = last_data_q;
        iwait_d     = 1'b1;
        dwait_d     = 1'b1;
        iload_d     = '0;
        dload_d     = '0;
        err_d       = err_q;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        req_held    = 1'b0;
        done        = 1'b0;
        done_val    = '0;
        dreq        = dREN | dWEN;
        timer_en    = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                // A pending wait-low pulse means a completion is being presented this cycle
                if (iwait_q && dwait_q) begin
                    if (dreq && (!iREN || !last_data_q)) begin
                        addr_d      = daddr;
                        store_d     = dstore;
                        wen_d       = dWEN;
                        last_data_d = 1'b1;
                        state_d     = StDServ;
                    end else if (iREN) begin
                        addr_d      = iaddr;
                        store_d     = '0;
                        wen_d       = 1'b0;
                        last_data_d = 1'b0;
                        state_d     = StIServ;
                    end
                end
            end
            StDServ, StIServ: begin
                ramREN   = !wen_q;
                ramWEN   = wen_q;
                ramaddr  = addr_q;
                ramstore = store_q;
                req_held = (state_q == StDServ) ? dreq : iREN;
                if (!req_held) begin
                    state_d = StIdle;
                end else if (ramstate == ACCESS) begin
                    done     = 1'b1;
                    done_val = wen_q ? '0 : ramload;
                end else if (ramstate == ERROR || expired) begin
                    done     = 1'b1;
                    done_val = BadWord;
                    err_d    = 1'b1;
                end
                if (done) begin
                    state_d = StIdle;
                    if (state_q == StDServ) begin
                        dwait_d = 1'b0;
                        dload_d = done_val;
                    end else begin
                        iwait_d = 1'b0;
                        iload_d = done_val;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        timer_clr = (state_d == StIdle);

        // Outputs are held at their idle values while reset is applied
        if (RST) begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
        end
        iwait = iwait_q | RST;
        dwait = dwait_q | RST;
        iload = RST ? '0 : iload_q;
        dload = RST ? '0 : dload_q;
        err   = err_q & !RST;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            store_q     <= '0;
            wen_q       <= 1'b0;
            last_data_q <= 1'b0;
            iwait_q     <= 1'b1;
            dwait_q     <= 1'b1;
            iload_q     <= '0;
            dload_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            wen_q       <= wen_d;
            last_data_q <= last_data_d;
            iwait_q     <= iwait_d;
            dwait_q     <= dwait_d;
            iload_q     <= iload_d;
            dload_q     <= dload_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder with a small latency-programmable RAM model.
module tb_mem_responder;
    import cpu_types_pkg::*;

    localparam int unsigned TO = 8;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait, ramREN, ramWEN, err;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    int        n_chk = 0;
    int        n_fail = 0;
    int        ram_lat = 0;
    logic      ram_err = 1'b0;
    word_t     ram_word = '0;
    int        busy_cnt = 0;
    logic      ram_act;

    typedef struct {
        logic  is_d;
        word_t load;
    } exp_t;
    exp_t sb[$];

    mem_responder #(
        .TIMEOUT (TO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    // RAM model: ram_lat BUSY cycles then ACCESS; ram_lat < 0 never completes
    assign ram_act = ramREN | ramWEN;
    always_comb begin
        ramstate = BUSY;
        if (!ram_act) ramstate = FREE;
        else if (ram_err) ramstate = ERROR;
        else if (ram_lat >= 0 && busy_cnt == ram_lat) ramstate = ACCESS;
        ramload = ram_word + ramaddr;
    end
    always @(posedge CLK) busy_cnt <= (ram_act && ramstate != ACCESS) ? busy_cnt + 1 : 0;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
        step(); step();
        n_chk++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL reset_iwait got %b want 1", iwait); end
        n_chk++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL reset_dwait got %b want 1", dwait); end
        n_chk++; if ({iload, dload} !== 64'h0) begin n_fail++; $display("FAIL reset_loads got %h want 0", {iload, dload}); end
        n_chk++; if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'h0) begin
            n_fail++; $display("FAIL reset_ram got %b%b %h %h want 0", ramREN, ramWEN, ramaddr, ramstore);
        end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        RST = 1'b0;
        step();
    endtask

    task automatic test_instr_read;
        ram_lat = 0; ram_word = 32'h8C220004 - 32'h40;
        iaddr = 32'h40; iREN = 1'b1;
        step();
        n_chk++; if ({iwait, ramREN, ramaddr} !== {1'b1, 1'b1, 32'h40}) begin
            n_fail++; $display("FAIL iread_svc got iwait=%b ren=%b addr=%h want 1 1 40", iwait, ramREN, ramaddr);
        end
        step();
        n_chk++; if ({iwait, dwait} !== 2'b01) begin n_fail++; $display("FAIL iread_wait got %b want 01", {iwait, dwait}); end
        n_chk++; if (iload !== 32'h8C220004) begin n_fail++; $display("FAIL iread_load got %h want 8c220004", iload); end
        iREN = 1'b0;
        step();
        n_chk++; if ({iwait, ramREN} !== 2'b10) begin n_fail++; $display("FAIL iread_idle got %b want 10", {iwait, ramREN}); end
    endtask

    task automatic test_write;
        int got = -1;
        ram_lat = 2;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        for (int s = 1; s <= 12 && got < 0; s++) begin
            step();
            if (s <= 3) begin
                n_chk++; if ({ramREN, ramWEN, ramaddr, ramstore} !== {2'b01, 32'h80, 32'hDEADBEEF}) begin
                    n_fail++; $display("FAIL write_ram_c%0d got %b%b %h %h want 01 80 deadbeef", s, ramREN, ramWEN, ramaddr, ramstore);
                end
            end
            if (dwait === 1'b0) begin
                got = s;
                n_chk++; if (dload !== 32'h0) begin n_fail++; $display("FAIL write_dload got %h want 0", dload); end
            end
        end
        n_chk++; if (got != 4) begin n_fail++; $display("FAIL write_latency got %0d want 4", got); end
        dWEN = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        logic both_low = 1'b0;
        RST = 1'b1; step(); RST = 1'b0;
        ram_lat = 3; ram_word = 32'h1000_0000;
        daddr = 32'h100; iaddr = 32'h200;
        sb.push_back('{1'b1, 32'h1000_0100});
        sb.push_back('{1'b0, 32'h1000_0200});
        sb.push_back('{1'b1, 32'h1000_0104});
        sb.push_back('{1'b0, 32'h1000_0204});
        dREN = 1'b1; iREN = 1'b1;
        for (int s = 0; s < 80 && sb.size() > 0; s++) begin
            step();
            if (!iwait && !dwait) both_low = 1'b1;
            if (!iwait || !dwait) begin
                exp_t e = sb.pop_front();
                n_chk++; if (!dwait !== e.is_d) begin
                    n_fail++; $display("FAIL arb_order got data=%b want data=%b", !dwait, e.is_d);
                end
                n_chk++; if ((e.is_d ? dload : iload) !== e.load) begin
                    n_fail++; $display("FAIL arb_load got %h want %h", e.is_d ? dload : iload, e.load);
                end
                if (!dwait) daddr = daddr + 32'h4;
                else iaddr = iaddr + 32'h4;
            end
        end
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL arb_pending got %0d want 0", sb.size()); sb.delete(); end
        n_chk++; if (both_low !== 1'b0) begin n_fail++; $display("FAIL arb_both_low got %b want 0", both_low); end
        dREN = 1'b0; iREN = 1'b0;
        step();
    endtask

    task automatic test_abort;
        logic seen_low = 1'b0;
        ram_lat = -1; iaddr = 32'h44; iREN = 1'b1;
        step();
        n_chk++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL abort_svc got %b want 1", ramREN); end
        step();
        iREN = 1'b0;
        for (int s = 0; s < 4; s++) begin
            step();
            if (iwait === 1'b0) seen_low = 1'b1;
            if (s == 0) begin
                n_chk++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL abort_idle got ren=%b want 0", ramREN); end
            end
        end
        n_chk++; if (seen_low !== 1'b0) begin n_fail++; $display("FAIL abort_iwait got low=%b want 0", seen_low); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err got %b want 0", err); end
    endtask

    task automatic test_ram_error;
        ram_err = 1'b1; iaddr = 32'h48; iREN = 1'b1;
        step(); step();
        n_chk++; if ({iwait, iload} !== {1'b0, 32'hBAD1BAD1}) begin
            n_fail++; $display("FAIL ramerr_done got %b %h want 0 bad1bad1", iwait, iload);
        end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL ramerr_err got %b want 1", err); end
        iREN = 1'b0; ram_err = 1'b0;
        step();
    endtask

    task automatic test_reset_mid;
        ram_lat = -1; daddr = 32'h50; dREN = 1'b1;
        step(); step();
        n_chk++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL rstmid_svc got %b want 1", ramREN); end
        RST = 1'b1;
        step();
        n_chk++; if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'h0) begin
            n_fail++; $display("FAIL rstmid_ram got %b%b %h %h want 0", ramREN, ramWEN, ramaddr, ramstore);
        end
        n_chk++; if ({iwait, dwait, dload} !== {2'b11, 32'h0}) begin
            n_fail++; $display("FAIL rstmid_waits got %b%b %h want 11 0", iwait, dwait, dload);
        end
        RST = 1'b0; dREN = 1'b0;
        step();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err got %b want 0", err); end
    endtask

    task automatic test_timeout;
        int got = -1;
        ram_lat = -1; daddr = 32'h300; dREN = 1'b1;
        sb.push_back('{1'b1, 32'hBAD1BAD1});
        for (int s = 1; s <= 20 && got < 0; s++) begin
            step();
            if (dwait === 1'b0) begin
                exp_t e = sb.pop_front();
                got = s;
                n_chk++; if (dload !== e.load) begin n_fail++; $display("FAIL timeout_load got %h want %h", dload, e.load); end
                n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %b want 1", err); end
            end
        end
        n_chk++; if (got != int'(TO) + 1) begin n_fail++; $display("FAIL timeout_cycle got %0d want %0d", got, TO + 1); end
        sb.delete();
        dREN = 1'b0;
        repeat (20) step();
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_write();
        test_back_to_back();
        test_abort();
        test_ram_error();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum service cycles before a forced error completion.
REQ-002 SHALL have port CLK  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port iREN  in  1  instruction read request, held by requester until iwait low.
REQ-005 SHALL have port iaddr  in  32  instruction word address.
REQ-006 SHALL have port iwait  out  1  low for exactly one cycle when an instruction read completes; high otherwise.
REQ-007 SHALL have port iload  out  32  instruction data, valid only in the cycle iwait is low.
REQ-008 SHALL have ports dREN  in  1,  dWEN  in  1,  daddr  in  32,  dstore  in  32  for the data request.
REQ-009 SHALL have ports dwait  out  1,  dload  out  32, with the same completion rules as iwait/iload.
REQ-010 SHALL have ports ramREN  out  1,  ramWEN  out  1,  ramaddr  out  32,  ramstore  out  32  to the RAM.
REQ-011 SHALL have ports ramload  in  32  and ramstate  in  ramstate_t (FREE, BUSY, ACCESS, ERROR).
REQ-012 SHALL have port err  out  1  sticky error flag.

Function
REQ-013 SHALL implement FSM states IDLE, DSERV, ISERV.
REQ-014 In IDLE with only dREN|dWEN asserted, SHALL latch daddr, dstore and the dWEN op, then go to DSERV.
REQ-015 In IDLE with only iREN asserted, SHALL latch iaddr and go to ISERV.
REQ-016 In IDLE with both pending, SHALL grant data unless the previous grant was data; then instruction is granted (anti-starvation).
REQ-017 In DSERV/ISERV, SHALL drive ramaddr, ramstore, ramREN and ramWEN from the latched request only; all RAM outputs are 0 in IDLE.
REQ-018 In DSERV/ISERV, the service counter SHALL increment each cycle; it clears on entry to IDLE.
REQ-019 When ramstate==ACCESS, SHALL drive the granted wait low for that cycle, drive load=ramload (0 for writes), and return to IDLE.
REQ-020 When ramstate==ERROR, or the counter reaches TIMEOUT, SHALL drive wait low, drive load=32'hBAD1BAD1, set err, and return to IDLE.
REQ-021 If the granted requester deasserts its request mid-service, SHALL return to IDLE without a wait-low pulse and without setting err.
REQ-022 The non-granted wait SHALL stay high throughout a service.
REQ-023 Minimum latency SHALL be 2 cycles (request visible in IDLE, ACCESS in the first service cycle gives wait low the next cycle); each completion is followed by at least one IDLE cycle.
REQ-024 A request asserted in the same cycle as a completion SHALL be considered only in the following IDLE cycle.
REQ-025 err SHALL stay set until reset.

Reset
REQ-026 RST high at a clock edge SHALL force IDLE, clear the counter, the latches, err and the last-grant flag, even mid-service.
REQ-027 During and after reset, SHALL hold iwait=1, dwait=1, iload=0, dload=0 and all RAM outputs 0.

Structure
REQ-028 ramstate_t, word_t and the 32'hBAD1BAD1 poison constant SHALL come from cpu_types_pkg; the FSM state enum stays local.
REQ-029 The service counter and timeout compare SHALL be one sub-module, svc_timer (inputs clr, en; output expired).
REQ-030 Everything else SHALL be a single always_ff plus a single always_comb in mem_responder.

Verification
REQ-031 iREN=1, iaddr=0x40, ramstate ACCESS on the first service cycle, ramload=0x8C220004 -> iwait low exactly one cycle at cycle 2 with iload=0x8C220004, then IDLE.
REQ-032 dREN and iREN asserted together from reset, each RAM access taking 3 BUSY cycles -> data served first, instruction next, then data again (alternating); no cycle with both waits low.
REQ-033 dWEN=1, daddr=0x80, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x80, ramstore=0xDEADBEEF until ACCESS; dwait low one cycle with dload=0.
REQ-034 ramstate held BUSY with TIMEOUT=8 -> wait low at service cycle 8, load=0xBAD1BAD1, err=1, err still 1 after 20 further cycles.
REQ-035 iREN dropped at service cycle 2 -> IDLE next cycle, iwait never low, err=0; RST asserted mid-DSERV -> RAM outputs 0 and both waits high on the next edge.
